// File: rtl/mesh_wormhole_pkg.sv
// Shared definitions for the mesh wormhole node: flit types and the output allocator FSM encoding.
package mesh_wormhole_pkg;

    localparam int unsigned FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_INVALID = 2'b00,
        FLIT_HEAD    = 2'b01,
        FLIT_BODY    = 2'b10,
        FLIT_TAIL    = 2'b11
    } flit_id_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/hop_cnt_priority_arbiter.sv
// Combinational arbiter: picks the requester with the largest hop count, lowest index on ties.
module hop_cnt_priority_arbiter #(
    parameter int unsigned N     = 5,
    parameter int unsigned HOP_W = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]       req,
    input  logic [N*HOP_W-1:0] hop_cnt,
    output logic [N-1:0]       gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [HOP_W-1:0] best_hop;

    // Strict greater-than keeps the earliest (lowest index) candidate on equal hop counts.
    always_comb begin
        found    = 1'b0;
        best_hop = '0;
        idx      = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && (!found || (hop_cnt[HOP_W*i +: HOP_W] > best_hop))) begin
                found    = 1'b1;
                best_hop = hop_cnt[HOP_W*i +: HOP_W];
                idx      = IDX_W'(i);
            end
        end
        gnt = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/wormhole_output_allocator.sv
// Per-output allocator: grants one input VC by hop count and holds the lock until its tail flit passes.
module wormhole_output_allocator
    import mesh_wormhole_pkg::*;
#(
    parameter  int unsigned IN_N      = 5,
    parameter  int unsigned HOP_CNT_W = 4,
    parameter  int unsigned FLIT_ID_W = 2,
    localparam int unsigned SEL_W     = (IN_N > 1) ? $clog2(IN_N) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IN_N-1:0]           req_i,
    input  logic [IN_N*HOP_CNT_W-1:0] hop_cnt_i,
    input  logic [IN_N*FLIT_ID_W-1:0] flit_id_i,
    input  logic [IN_N-1:0]           vc_vld_i,
    input  logic                      out_rdy_i,
    output logic [IN_N-1:0]           grant_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic [IN_N-1:0]           vc_rd_o,
    output logic                      out_vld_o,
    output logic                      busy_o,
    output logic                      err_o
);

    alloc_state_e           state_q, state_d;
    logic [IN_N-1:0]        grant_q, grant_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   err_q, err_d;
    logic                   first_q, first_d;

    logic [IN_N-1:0]        arb_gnt;
    logic [SEL_W-1:0]       arb_idx;
    logic [FLIT_ID_W-1:0]   flit_g;
    logic                   vld_g;
    logic                   xfer;

    hop_cnt_priority_arbiter #(
        .N     (IN_N),
        .HOP_W (HOP_CNT_W),
        .IDX_W (SEL_W)
    ) u_arb (
        .req     (req_i),
        .hop_cnt (hop_cnt_i),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    // Granted VC's front flit, selected through the one-hot grant.
    always_comb begin
        flit_g = '0;
        for (int i = 0; i < int'(IN_N); i++) begin
            if (grant_q[i]) begin
                flit_g = flit_g | flit_id_i[FLIT_ID_W*i +: FLIT_ID_W];
            end
        end
        vld_g = |(vc_vld_i & grant_q);
        xfer  = (state_q == ST_LOCKED) & vld_g & out_rdy_i;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        err_d     = err_q;
        first_d   = first_q;
        vc_rd_o   = '0;
        out_vld_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_LOCKED;
                    grant_d = arb_gnt;
                    sel_d   = arb_idx;
                    first_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    vc_rd_o   = grant_q;
                    out_vld_o = 1'b1;
                    first_d   = 1'b0;
                    // A HEAD is only legal as the packet's first transfer.
                    if ((flit_g == FLIT_ID_W'(FLIT_INVALID)) ||
                        ((flit_g == FLIT_ID_W'(FLIT_HEAD)) && !first_q)) begin
                        err_d = 1'b1;
                    end
                    if (flit_g == FLIT_ID_W'(FLIT_TAIL)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        sel_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign grant_o = grant_q;
    assign sel_o   = sel_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q == ST_LOCKED);

endmodule

// File: doc/wormhole_output_allocator.md
# wormhole_output_allocator

Per-output-channel resource allocator for the 2D-mesh wormhole node; one instance sits in front of each crossbar output. Picks one requesting input virtual channel by hop count, with static index priority on ties, and locks that input to the output until the packet's tail flit has passed. While locked, it drives the crossbar select, pops the granted VC and qualifies output valid against downstream backpressure.

## Interface
- `IN_N`, 5: number of input VCs competing for this output.
- `HOP_CNT_W`, 4: hop-count field width.
- `FLIT_ID_W`, 2: flit-type field width.
- `SEL_W`, `$clog2(IN_N)`: crossbar select width (localparam).

Ports:
- `clk_i`  in  1  clock; all state is updated on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  IN_N  VC[i] has a head flit at its front, routed to this output.
- `hop_cnt_i`  in  IN_N*HOP_CNT_W  hop count of each VC's head flit; slice i is `[HOP_CNT_W*(i+1)-1 : HOP_CNT_W*i]`.
- `flit_id_i`  in  IN_N*FLIT_ID_W  flit type at the front of each VC.
- `vc_vld_i`  in  IN_N  VC[i] is non-empty.
- `out_rdy_i`  in  1  downstream FIFO not full.
- `grant_o`  out  IN_N  one-hot registered grant, or all zero.
- `sel_o`  out  SEL_W  binary index of the granted VC, for the crossbar.
- `vc_rd_o`  out  IN_N  pop strobe to the granted VC.
- `out_vld_o`  out  1  write enable to the downstream FIFO.
- `busy_o`  out  1  output is locked to a packet.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- Flit IDs: HEAD=2'b01, BODY=2'b10, TAIL=2'b11, 2'b00 invalid.
  - A packet is HEAD, then zero or more BODY flits, then TAIL, so the minimum packet is 2 flits.
- FSM states: IDLE and LOCKED.
- IDLE:
  - If `|req_i`, the winner is the requester with the largest `hop_cnt_i`; on equal hop counts the lowest index wins.
  - The winner is registered into `grant_o`/`sel_o` and the FSM moves to LOCKED.
  - Requests that lose are not remembered; they must hold `req_i`.
- LOCKED, with g the granted index:
  - Transfer condition: `xfer = vc_vld_i[g] & out_rdy_i`.
  - `vc_rd_o[g] = out_vld_o = xfer`, combinational. All other `vc_rd_o` bits stay 0.
  - If `xfer` and `flit_id_i[g]==TAIL`, the FSM returns to IDLE and `grant_o` clears on the next edge.
  - `req_i` is ignored while LOCKED.
- Outputs in IDLE: `vc_rd_o=0`, `out_vld_o=0`.
- `busy_o` = (state==LOCKED).
- `err_o` sets when `xfer` occurs with a granted flit ID of HEAD (after the first transfer of the packet) or invalid. It stays set until reset; the transfer itself still proceeds.

## Timing
- Reset values: state=IDLE, `grant_o=0`, `sel_o=0`, `busy_o=0`, `err_o=0`. `vc_rd_o` and `out_vld_o` are 0 whenever IDLE.
- Allocation latency: request sampled in cycle N, grant visible in N+1, first flit can transfer in N+1.
- Packet of F flits with no stalls: the output is busy for F cycles, plus 1 IDLE bubble before the next allocation.
- Stall rules:
  - `out_rdy_i=0` or `vc_vld_i[g]=0` holds the lock with no pop and no valid.
  - The lock is never dropped mid-packet.
- Tail transfer and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
- Reset mid-packet clears the lock immediately and asynchronously. Flushing the partial packet is upstream's responsibility.
- Hop count is compared unsigned; max value (all ones) is a legal value and wins.

## Structure
- Shared package `mesh_wormhole_pkg`: flit ID constants (HEAD/BODY/TAIL/INVALID) and FSM state encoding, reused by the VC and node.
- Sub-module `hop_cnt_priority_arbiter`:
  - Purely combinational: `req`, `hop_cnt` in; one-hot `gnt` and binary `idx` out.
  - Implemented as a linear or tree compare with strict greater-than, so lower indices win ties.
- The allocator instantiates the arbiter and owns the FSM, grant registers and error flag.

## Test plan
- Single request: `req_i=5'b00100`, VC2 sends HEAD, BODY, TAIL with `out_rdy_i=1` -> `grant_o=00100` and `sel_o=2` from the next cycle; `out_vld_o` high 3 cycles; then IDLE.
- Hop priority: `req_i=5'b10011` with hop counts VC0=3, VC1=7, VC4=7 -> grant VC1 (tie with VC4 broken by index); VC4 is granted after VC1's TAIL plus 1 bubble.
- Backpressure: `out_rdy_i` low for 4 cycles mid-packet -> no `vc_rd_o`/`out_vld_o` for those cycles; `grant_o` unchanged; the packet completes once ready returns.
- VC underflow: `vc_vld_i[g]=0` for 2 cycles between BODY flits while another VC requests -> lock held; the competitor is not granted until the TAIL transfers.
- Reset mid-packet: assert `rst_ni=0` after 1 of 4 flits -> `grant_o=0`, `busy_o=0` asynchronously; a fresh request after release is allocated normally.
- Protocol error: the granted VC presents HEAD as its second flit -> `err_o` rises and stays 1 until reset.
